// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, reg_write,
           mem_read, mem_write, i_or_d, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, reg_write,
           mem_read, mem_write, i_or_d, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style main control FSM for a multicycle MIPS subset
// (lw, sw, R-type, beq, addi, j) with memory wait-state handshake.
module multicycle_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXEC    = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;
  localparam logic [3:0] ILLEGAL = 4'd12;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;

  logic [16:0] ctrl_raw;
  logic [16:0] ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR:  state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
      EXEC:    state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      DECODE:  alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
      end
      ADDIWB:  reg_write = 1'b1;
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  // Reset gates the outputs directly so FETCH's strobes stay low while reset is held.
  assign ctrl_raw = {pc_write, pc_write_cond, ir_write, reg_write,
                     mem_read, mem_write, i_or_d, mem_to_reg, reg_dst,
                     alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
  assign ctrl     = reset ? ctrl_raw : '0;

  assign {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write,
          bus.mem_read, bus.mem_write, bus.i_or_d, bus.mem_to_reg, bus.reg_dst,
          bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
          bus.illegal_op} = ctrl;
  assign bus.state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths and encodings are fixed by this document.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction bits [31:26], valid from the DECODE cycle onward.
REQ-005 mem_ready  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-006 pc_write, pc_write_cond, ir_write, reg_write  output  1 each  register write enables for the PC, IR and register file.
REQ-007 mem_read, mem_write, i_or_d  output  1 each  memory strobes; i_or_d 0 = PC address, 1 = ALU-out address.
REQ-008 mem_to_reg, reg_dst, alu_src_a  output  1 each  datapath mux selects.
REQ-009 alu_src_b, alu_op, pc_src  output  2 each  datapath mux selects and ALU class.
REQ-010 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-011 state  output  4  current state encoding, for debug.

Function
REQ-012 The block SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-013 Outputs SHALL be combinational from state only, except that ir_write and pc_write in FETCH SHALL equal mem_ready; any output not listed for a state SHALL be 0.
REQ-014 FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_src=00, i_or_d=0, ir_write=pc_write=mem_ready; stay while mem_ready=0; go to DECODE when mem_ready=1.
REQ-015 DECODE: alu_src_b=11, alu_op=00; next state by opcode:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other -> ILLEGAL
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEMRD if opcode=100011, else MEMWR.
REQ-017 MEMRD: mem_read=1, i_or_d=1; stay while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-018 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; go to FETCH.
REQ-019 MEMWR: mem_write=1, i_or_d=1; stay while mem_ready=0; go to FETCH when mem_ready=1.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; go to ALUWB.
REQ-021 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1; go to FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-024 JUMP: pc_write=1, pc_src=10; go to FETCH.
REQ-025 ILLEGAL: illegal_op=1 for exactly one cycle, then FETCH; no register write enable is asserted.
REQ-026 Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3; each wait state adds one cycle.
REQ-027 mem_read and mem_write SHALL never both be 1, and at most one of pc_write, reg_write and ir_write SHALL be 1 in any state other than FETCH.
REQ-028 The opcode input SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-029 While reset=0, state SHALL be FETCH asynchronously and all outputs SHALL be 0, including the mem_read, ir_write and pc_write terms of FETCH.
REQ-030 After reset deasserts, the first rising edge SHALL evaluate FETCH normally with mem_read=1.
REQ-031 Reset asserted mid-instruction (e.g. during a MEMRD wait) SHALL abort the instruction immediately with no further write enables.

Verification
REQ-032 Reset release, mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in the state-4 cycle; mem_to_reg=1.
REQ-033 opcode=101011, mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles with mem_write=1, then state 0; reg_write never 1.
REQ-034 FETCH with mem_ready=0 for 2 cycles, then 1 -> mem_read=1 for 3 cycles; ir_write and pc_write both 1 only in the third cycle.
REQ-035 Sequence 000000, 000100, 000010, 001000 -> per-instruction cycle counts 4, 3, 3, 4; pc_src=01 in BRANCH and 10 in JUMP.
REQ-036 opcode=111111 -> states 0,1,12,0; illegal_op high for exactly 1 cycle; no write enables asserted.
REQ-037 reset=0 asserted asynchronously during the state-3 wait -> state=0 and all outputs 0 before the next clk edge.
